alu_seq: RTL

- Registered, width-parametrised ALU. Successor to the 4-bit combinational ALU; keeps its opcode map 0001–1000 unchanged.
- Adds:
  - start/busy/done handshake;
  - a Z flag;
  - a carry-chained add (ADC) that uses the stored carry flag, for multi-word arithmetic;
  - multi-cycle barrel-free shifts by a variable amount, one bit per cycle.
- Sits between the register-file read port and the writeback path of the datapath.

---
 rtl/alu_seq_if.sv | 26 ++
 rtl/alu_seq.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/alu_seq_if.sv
// Operand/result bundle of alu_seq: request side from the register file, result side to writeback.
interface alu_seq_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [3:0]       OPCODE;
    logic [WIDTH-1:0] aluin_a;
    logic [WIDTH-1:0] aluin_b;
    logic             Cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] alu_out;
    logic             Cout;
    logic             OF;
    logic             Z;

    modport master (
        output start, OPCODE, aluin_a, aluin_b, Cin,
        input  busy, done, alu_out, Cout, OF, Z
    );

    modport slave (
        input  start, OPCODE, aluin_a, aluin_b, Cin,
        output busy, done, alu_out, Cout, OF, Z
    );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with start/busy/done handshake, stored-carry ADC and bit-serial variable shifts.
module alu_seq #(
    parameter int unsigned WIDTH = 8
) (
    input logic     clk,
    input logic     rst,
    alu_seq_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH);

    localparam logic [3:0] OpAddc = 4'b0001;
    localparam logic [3:0] OpAdd  = 4'b0010;
    localparam logic [3:0] OpSub  = 4'b0011;
    localparam logic [3:0] OpAnd  = 4'b0100;
    localparam logic [3:0] OpNor  = 4'b0101;
    localparam logic [3:0] OpXnor = 4'b0110;
    localparam logic [3:0] OpNot  = 4'b0111;
    localparam logic [3:0] OpLsr1 = 4'b1000;
    localparam logic [3:0] OpLsrk = 4'b1001;
    localparam logic [3:0] OpLslk = 4'b1010;
    localparam logic [3:0] OpAdc  = 4'b1011;

    typedef enum logic {StIdle, StShift} state_e;

    state_e           r_state;
    state_e           w_state_d;
    logic [WIDTH-1:0] r_work;
    logic [CW-1:0]    r_cnt;
    logic             r_dir;      // 1: shift left
    logic [WIDTH-1:0] r_out;
    logic             r_cout;
    logic             r_of;
    logic             r_z;
    logic             r_done;

    logic             w_accept;
    logic             w_is_shift;
    logic [CW-1:0]    w_k;
    logic             w_start_shift;
    logic [WIDTH-1:0] w_b_op;
    logic             w_cin;
    logic [WIDTH:0]   w_sum;
    logic             w_sum_of;
    logic [WIDTH-1:0] w_res;
    logic             w_res_c;
    logic             w_res_of;
    logic [WIDTH-1:0] w_work_sh;
    logic             w_sh_out;
    logic             w_last_step;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (w_start_shift) w_state_d = StShift;
            StShift: if (w_last_step) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // Output and datapath combinational logic
    always_comb begin
        w_accept      = bus.start && (r_state == StIdle);
        w_is_shift    = (bus.OPCODE == OpLsrk) || (bus.OPCODE == OpLslk);
        w_k           = bus.aluin_b[CW-1:0];
        w_start_shift = w_accept && w_is_shift && (w_k != '0);
        w_last_step   = (r_state == StShift) && (r_cnt == CW'(1));

        w_b_op = (bus.OPCODE == OpSub) ? ~bus.aluin_b : bus.aluin_b;
        unique case (bus.OPCODE)
            OpAddc:  w_cin = bus.Cin;
            OpSub:   w_cin = 1'b1;
            OpAdc:   w_cin = r_cout;
            default: w_cin = 1'b0;
        endcase
        w_sum = {1'b0, bus.aluin_a} + {1'b0, w_b_op} + (WIDTH + 1)'(w_cin);
        // Carry into the MSB is recovered from the MSB sum bit and its operands.
        w_sum_of = bus.aluin_a[WIDTH-1] ^ w_b_op[WIDTH-1] ^ w_sum[WIDTH-1] ^ w_sum[WIDTH];

        w_res    = '0;
        w_res_c  = 1'b0;
        w_res_of = 1'b0;
        case (bus.OPCODE)
            OpAddc, OpAdd, OpSub, OpAdc: begin
                w_res    = w_sum[WIDTH-1:0];
                w_res_c  = w_sum[WIDTH];
                w_res_of = w_sum_of;
            end
            OpAnd:          w_res = bus.aluin_a & bus.aluin_b;
            OpNor:          w_res = ~(bus.aluin_a | bus.aluin_b);
            OpXnor:         w_res = ~(bus.aluin_a ^ bus.aluin_b);
            OpNot:          w_res = ~bus.aluin_a;
            OpLsr1:         w_res = bus.aluin_a >> 1;
            OpLsrk, OpLslk: w_res = bus.aluin_a;   // only reached with k == 0
            default:        w_res = '0;
        endcase

        w_work_sh = r_dir ? (r_work << 1) : (r_work >> 1);
        w_sh_out  = r_dir ? r_work[WIDTH-1] : r_work[0];

        bus.busy    = (r_state == StShift);
        bus.done    = r_done;
        bus.alu_out = r_out;
        bus.Cout    = r_cout;
        bus.OF      = r_of;
        bus.Z       = r_z;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_work <= '0;
            r_cnt  <= '0;
            r_dir  <= 1'b0;
            r_out  <= '0;
            r_cout <= 1'b0;
            r_of   <= 1'b0;
            r_z    <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_start_shift) begin
                r_work <= bus.aluin_a;
                r_cnt  <= w_k;
                r_dir  <= (bus.OPCODE == OpLslk);
            end else if (w_accept) begin
                r_out  <= w_res;
                r_cout <= w_res_c;
                r_of   <= w_res_of;
                r_z    <= (w_res == '0);
                r_done <= 1'b1;
            end else if (r_state == StShift) begin
                r_work <= w_work_sh;
                r_cnt  <= r_cnt - CW'(1);
                // Result is published only on the final step; alu_out holds meanwhile.
                if (w_last_step) begin
                    r_out  <= w_work_sh;
                    r_cout <= w_sh_out;
                    r_of   <= 1'b0;
                    r_z    <= (w_work_sh == '0);
                    r_done <= 1'b1;
                end
            end
        end
    end
endmodule
